uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver: 8N1, LSB first, fixed baud set by parameter.
- Sits directly upstream of the state watcher and every other command consumer.
- Drives the shared Rx_data / Rx_ready bus those consumers decode.
- Reports framing errors separately; a bad frame never raises Rx_ready.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); legal range >= 4; elaboration fails below 4.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Rx  in  1  serial line, idle high, asynchronous to clk
Rx_data  out  8  last correctly received byte
Rx_ready  out  1  one-cycle pulse: new byte valid on Rx_data
Rx_frame_error  out  1  one-cycle pulse: stop bit sampled low
Rx_busy  out  1  high while a frame is being received (START/DATA/STOP/WAIT_IDLE)

Behaviour:
- Reset (reset=0, async assert, sync release):
  - Rx_data=8'h00; Rx_ready=0; Rx_frame_error=0; Rx_busy=0.
  - State=IDLE; both synchronizer flops=1.
  - Reset mid-frame abandons the frame with no pulse.
- Input sync:
  - Rx passes through a 2-flop synchronizer; rxs = synchronizer output.
  - All decisions use rxs only.
- Timing definitions:
  - Bit counter width is $clog2(CLKS_PER_BIT); H = CLKS_PER_BIT/2 (integer division).
  - t0 = first cycle in IDLE where rxs=0.
  - Start sample at t0+H.
  - Data bit k (k=0..7) sample at t0+H+(k+1)*CLKS_PER_BIT.
  - Stop sample at t0+H+9*CLKS_PER_BIT.
- FSM:
  - IDLE: rxs=0 -> START, clear counter.
  - START: at t0+H, if rxs=0 -> DATA; if rxs=1 (glitch) -> IDLE, no output activity.
  - DATA: at each bit sample, shift rxs in LSB first. After bit 7 -> STOP.
  - STOP, rxs=1:
    - Rx_data <= shift register; Rx_ready=1 in the following cycle only -> IDLE.
  - STOP, rxs=0:
    - Rx_frame_error=1 in the following cycle only; Rx_data unchanged -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1 (break / line-stuck-low handling) -> IDLE. No pulses while waiting.
- Rx_data holds its value until the next good frame; never changes except in the cycle Rx_ready rises.
- Rx_ready and Rx_frame_error are mutually exclusive; each lasts exactly one cycle, giving a clean posedge and negedge to downstream edge-triggered logic.
- Back-to-back frames: IDLE re-arms immediately after the stop sample, so a start bit following the stop bit with zero idle gap is received.
- Rx_busy: 0 in IDLE, 1 in all other states, registered.

Test Plan:
(all with CLKS_PER_BIT=16, so H=8)
- Byte 8'hA5, then line idle:
  - Rx_data=8'hA5; Rx_ready high exactly one cycle at t0+153; Rx_frame_error never high.
- Rx low for 4 cycles, then high:
  - No Rx_ready, no Rx_frame_error; Rx_busy drops after the start sample; Rx_data stays 8'h00.
- After good 8'hA5, send 8'h3C with stop bit 0, hold line low 50 cycles, then send 8'h00 normally:
  - One Rx_frame_error pulse; Rx_data stays 8'hA5 through the error; no pulses during the low hold.
  - Then Rx_ready with Rx_data=8'h00.
- Frames 8'h01, 8'hFF, 8'h80 back-to-back with zero idle bits:
  - Three Rx_ready pulses spaced exactly 160 cycles apart, with matching Rx_data values in order.
- Assert reset during data bit 4 of 8'h5A, release, then send 8'h7E:
  - All outputs 0 during reset; no pulse for the aborted frame.
  - Single Rx_ready with Rx_data=8'h7E.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver behind a 2-flop synchronizer.
// Good frames pulse Rx_ready and update Rx_data; a low stop bit pulses Rx_frame_error instead.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Rx,
   output logic [7:0] Rx_data,
   output logic       Rx_ready,
   output logic       Rx_frame_error,
   output logic       Rx_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;

   if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_receiver: CLKS_PER_BIT must be >= 4");
   end

   logic [1:0]    sync_q;
   logic          rxs;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          ready_q, ready_d;
   logic          ferr_q, ferr_d;
   logic          busy_q;

   assign rxs = sync_q[1];

   // Counter runs from the state entry; each sample point resets it so the next one lands a full bit later.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            state_d = rxs ? S_IDLE : S_START;
         end
         S_START: if (cnt_q == HALF_END) begin
            cnt_d   = '0;
            state_d = rxs ? S_IDLE : S_DATA;
         end
         S_DATA: if (cnt_q == FULL_END) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
         end
         S_STOP: if (cnt_q == FULL_END) begin
            cnt_d   = '0;
            data_d  = rxs ? shift_q : data_q;
            ready_d = rxs;
            ferr_d  = !rxs;
            state_d = rxs ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            cnt_d   = '0;
            state_d = rxs ? S_IDLE : S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], Rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign Rx_data        = data_q;
   assign Rx_ready       = ready_q;
   assign Rx_frame_error = ferr_q;
   assign Rx_busy        = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed vector table plus hand sequences for glitch, framing error,
// back-to-back frames and mid-frame reset, with CLKS_PER_BIT=16.
module tb_uart_receiver;
   localparam int CPB = 16;
   // Rx drop at a negedge -> 2 sync edges -> t0 edge, then H + 9 bits to the stop sample.
   localparam int LAT = 3 + CPB / 2 + 9 * CPB;

   logic       clk;
   logic       reset;
   logic       Rx;
   logic [7:0] Rx_data;
   logic       Rx_ready;
   logic       Rx_frame_error;
   logic       Rx_busy;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .reset(reset),
      .Rx(Rx),
      .Rx_data(Rx_data),
      .Rx_ready(Rx_ready),
      .Rx_frame_error(Rx_frame_error),
      .Rx_busy(Rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;
   int n_ready = 0;
   int n_ferr = 0;
   int viol = 0;
   int last_ready_cyc = 0;
   int rdy_cyc[$];
   logic [7:0] rdy_data[$];
   logic prev_ready = 1'b0;
   logic prev_ferr = 1'b0;
   logic prev_rst = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (reset && prev_rst) begin
         if (Rx_ready) begin
            n_ready++;
            last_ready_cyc = cyc;
            rdy_cyc.push_back(cyc);
            rdy_data.push_back(Rx_data);
         end
         if (Rx_frame_error) n_ferr++;
         if ((Rx_ready && prev_ready) || (Rx_frame_error && prev_ferr) || (Rx_ready && Rx_frame_error)) viol++;
         if (Rx_data !== prev_data && !Rx_ready) viol++;
      end
      prev_ready = Rx_ready;
      prev_ferr  = Rx_frame_error;
      prev_data  = Rx_data;
      prev_rst   = reset;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle(input int n);
      Rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      Rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         Rx = b[k];
         repeat (CPB) @(negedge clk);
      end
      Rx = stop;
      repeat (CPB) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] din;
      logic       stop;
      logic       exp_rdy;
      logic       exp_fe;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int r0, f0, t_start;
      logic [7:0] b5a;
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
      vecs[3] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
      vecs[4] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'h55};
      vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};

      reset = 1'b0;
      Rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", Rx_data, 8'h00);
      check("rst_ready", Rx_ready, 0);
      check("rst_ferr", Rx_frame_error, 0);
      check("rst_busy", Rx_busy, 0);
      reset = 1'b1;
      idle(10);

      // Glitch: 4 low cycles is rejected at the start sample.
      Rx = 1'b0;
      repeat (4) @(negedge clk);
      Rx = 1'b1;
      check("glitch_busy_hi", Rx_busy, 1);
      repeat (8) @(negedge clk);
      check("glitch_busy_lo", Rx_busy, 0);
      idle(20);
      check("glitch_ready", n_ready, 0);
      check("glitch_ferr", n_ferr, 0);
      check("glitch_data", Rx_data, 8'h00);

      for (int i = 0; i < 6; i++) begin
         r0 = n_ready;
         f0 = n_ferr;
         t_start = cyc;
         send_frame(vecs[i].din, vecs[i].stop);
         idle(20);
         check($sformatf("vec%0d_ready", i), n_ready - r0, {31'd0, vecs[i].exp_rdy});
         check($sformatf("vec%0d_ferr", i), n_ferr - f0, {31'd0, vecs[i].exp_fe});
         check($sformatf("vec%0d_data", i), Rx_data, vecs[i].exp_data);
         if (vecs[i].exp_rdy) check($sformatf("vec%0d_latency", i), last_ready_cyc - t_start, LAT);
      end

      // Framing error followed by a 50-cycle stuck-low line, then a good 8'h00.
      send_frame(8'hA5, 1'b1);
      idle(20);
      check("fe_pre_data", Rx_data, 8'hA5);
      r0 = n_ready;
      f0 = n_ferr;
      send_frame(8'h3C, 1'b0);
      repeat (50) @(negedge clk);
      check("fe_pulse", n_ferr - f0, 1);
      check("fe_no_ready", n_ready - r0, 0);
      check("fe_data_held", Rx_data, 8'hA5);
      check("fe_wait_busy", Rx_busy, 1);
      idle(16);
      send_frame(8'h00, 1'b1);
      idle(20);
      check("fe_after_ready", n_ready - r0, 1);
      check("fe_after_ferr", n_ferr - f0, 1);
      check("fe_after_data", Rx_data, 8'h00);

      // Back-to-back frames with no idle bits between them.
      rdy_cyc.delete();
      rdy_data.delete();
      send_frame(8'h01, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h80, 1'b1);
      idle(30);
      check("b2b_count", rdy_cyc.size(), 3);
      if (rdy_cyc.size() == 3) begin
         check("b2b_gap1", rdy_cyc[1] - rdy_cyc[0], 160);
         check("b2b_gap2", rdy_cyc[2] - rdy_cyc[1], 160);
         check("b2b_d0", rdy_data[0], 8'h01);
         check("b2b_d1", rdy_data[1], 8'hFF);
         check("b2b_d2", rdy_data[2], 8'h80);
      end

      // Reset in the middle of data bit 4 of 8'h5A.
      b5a = 8'h5A;
      r0 = n_ready;
      f0 = n_ferr;
      Rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         Rx = b5a[k];
         repeat (CPB) @(negedge clk);
      end
      Rx = b5a[4];
      repeat (CPB / 2) @(negedge clk);
      reset = 1'b0;
      Rx = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_data", Rx_data, 8'h00);
      check("mid_rst_ready", Rx_ready, 0);
      check("mid_rst_ferr", Rx_frame_error, 0);
      check("mid_rst_busy", Rx_busy, 0);
      reset = 1'b1;
      idle(CPB * 8);
      check("abort_no_ready", n_ready - r0, 0);
      check("abort_no_ferr", n_ferr - f0, 0);
      send_frame(8'h7E, 1'b1);
      idle(20);
      check("post_rst_ready", n_ready - r0, 1);
      check("post_rst_data", Rx_data, 8'h7E);

      check("pulse_rules", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
